// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port RAM controller.
// Parity support is compiled in only when RAM_PARITY_EN is defined.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  // Even-parity bit over up to 64 data bits; zero-extension leaves parity unchanged.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_sp_ctrl_if.sv
// Request/ready bus between the datapath and ram_sp_ctrl.
// RAM_PARITY_EN adds the parity error flag and the parity-inject input.
interface ram_sp_ctrl_if
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  // A request is taken on any rising edge where req_i=1 and ready_o=1;
  // a read answers one cycle later with rvalid_o=1 alongside the new dout_o.
  logic              clr_i;
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] din_i;
  logic              ready_o;
  logic [DATA_W-1:0] dout_o;
  logic              rvalid_o;
  state_e            state_o;
`ifdef RAM_PARITY_EN
  logic              perr_o;
  logic              perr_inj_i;

  modport master (
    output clr_i, req_i, we_i, addr_i, din_i, perr_inj_i,
    input  ready_o, dout_o, rvalid_o, state_o, perr_o
  );
  modport slave (
    input  clr_i, req_i, we_i, addr_i, din_i, perr_inj_i,
    output ready_o, dout_o, rvalid_o, state_o, perr_o
  );
`else
  modport master (
    output clr_i, req_i, we_i, addr_i, din_i,
    input  ready_o, dout_o, rvalid_o, state_o
  );
  modport slave (
    input  clr_i, req_i, we_i, addr_i, din_i,
    output ready_o, dout_o, rvalid_o, state_o
  );
`endif

endinterface

// File: rtl/ram_array.sv
// Plain single-port storage: synchronous write, registered read.
// Only the read register is reset; the array itself is left untouched.
module ram_array #(
  parameter int W      = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM with clear sequencer and request/ready handshake.
// Optional even parity per word is enabled with RAM_PARITY_EN.
module ram_sp_ctrl
  import ram_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic          clk_i,
  input logic          rst_i,
  ram_sp_ctrl_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rvalid_q;
  logic              mem_we, mem_re, inj;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rvalid_q  <= mem_re;
    end
  end

  // Reset blocks every array access; clr_i outranks any request.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = bus.addr_i;
    wr_data   = bus.din_i;
    inj       = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_CLEAR: begin
          mem_addr = clr_ptr_q;
          wr_data  = CLEAR_VAL;
          if (bus.clr_i) begin
            clr_ptr_d = '0;
          end else begin
            mem_we = 1'b1;
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            else clr_ptr_d = clr_ptr_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.clr_i) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
          end else if (bus.req_i) begin
            mem_we = bus.we_i;
            mem_re = !bus.we_i;
`ifdef RAM_PARITY_EN
            inj    = bus.perr_inj_i;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_PARITY_EN
  assign mem_wdata  = {even_parity(64'(wr_data)) ^ inj, wr_data};
  assign bus.perr_o = rvalid_q &
                      (even_parity(64'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W]);
`else
  assign mem_wdata  = wr_data;
`endif

  ram_array #(.W(MEM_W), .ADDR_W(ADDR_W)) u_array (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign bus.ready_o  = (state_q == ST_IDLE);
  assign bus.dout_o   = mem_rdata[DATA_W-1:0];
  assign bus.rvalid_o = rvalid_q;
  assign bus.state_o  = state_q;

  logic unused_inj;
  assign unused_inj = inj;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Self-checking bench for ram_sp_ctrl; define RAM_PARITY_EN to also
// exercise parity storage, injection and the error flag.
module tb_ram_sp_ctrl;
  import ram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_sp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL('0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model      [DEPTH];
  logic          model_perr [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic          exp_perr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model[i]      = '0;
      model_perr[i] = 1'b0;
    end
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic inj);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = AW'(a);
    bus.din_i  = d;
`ifdef RAM_PARITY_EN
    bus.perr_inj_i = inj;
`endif
    model[a]      = d;
    model_perr[a] = inj;
    cycle();
    bus.req_i = 1'b0;
`ifdef RAM_PARITY_EN
    bus.perr_inj_i = 1'b0;
`endif
  endtask

  task automatic do_read(input int a);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = AW'(a);
    exp_q.push_back(model[a]);
    exp_perr_q.push_back(model_perr[a]);
    cycle();
    bus.req_i = 1'b0;
    check($sformatf("rd_lat_%0d", a), 32'(bus.rvalid_o), 32'd1);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready_o && n < 200) begin
      cycle();
      n++;
    end
    if (!bus.ready_o) check("ready_timeout", 32'(bus.ready_o), 32'd1);
  endtask

  // Scoreboard: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        check("rd_data", 32'(bus.dout_o), 32'(exp_q.pop_front()));
`ifdef RAM_PARITY_EN
        check("perr", 32'(bus.perr_o), 32'(exp_perr_q.pop_front()));
`else
        void'(exp_perr_q.pop_front());
`endif
      end
    end
  end

  initial begin
    int n;
    bus.clr_i  = 1'b0;
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
    bus.din_i  = '0;
`ifdef RAM_PARITY_EN
    bus.perr_inj_i = 1'b0;
`endif
    model_clear();

    // Reset state and power-up clear length
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_dout", 32'(bus.dout_o), 32'd0);
    check("rst_state", 32'(bus.state_o), 32'(ST_CLEAR));
    rst = 1'b0;
    wait_ready(n);
    check("clr_len_init", 32'(n), 32'd32);
    check("idle_state", 32'(bus.state_o), 32'(ST_IDLE));
    do_read(0);
    do_read(17);
    do_read(31);
    cycle();

    // Writes then back-to-back reads
    do_write(0, 8'h03, 1'b0);
    do_write(1, 8'h02, 1'b0);
    do_write(2, 8'h04, 1'b0);
    do_read(0);
    do_read(1);
    do_read(2);
    cycle();

    // Write-then-read, and dout holds across a write
    do_write(5, 8'hA5, 1'b0);
    check("dout_hold", 32'(bus.dout_o), 32'h04);
    do_read(5);
    cycle();

    // Requests while clearing are ignored
    bus.clr_i = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    model_clear();
    repeat (4) cycle();
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = AW'(0);
    bus.din_i  = 8'hFF;
    cycle();
    bus.we_i   = 1'b0;
    bus.addr_i = AW'(5);
    cycle();
    bus.req_i = 1'b0;
    wait_ready(n);
    check("clr_len_req", 32'(n), 32'd26);
    do_read(0);
    do_read(5);
    cycle();

    // clr_i in IDLE drops a same-cycle write; restart clear at cycle 10
    bus.clr_i  = 1'b1;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = AW'(3);
    bus.din_i  = 8'hFF;
    cycle();
    bus.clr_i = 1'b0;
    bus.req_i = 1'b0;
    model_clear();
    repeat (9) cycle();
    bus.clr_i = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    wait_ready(n);
    check("clr_len_restart", 32'(n), 32'd32);
    do_read(3);
    cycle();

    // Reset mid-clear, with simultaneous clr_i
    bus.clr_i = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    repeat (19) cycle();
    rst       = 1'b1;
    bus.clr_i = 1'b1;
    cycle();
    check("rst_mid_clr_ready", 32'(bus.ready_o), 32'd0);
    check("rst_mid_clr_rvalid", 32'(bus.rvalid_o), 32'd0);
    rst       = 1'b0;
    bus.clr_i = 1'b0;
    wait_ready(n);
    check("clr_len_after_rst", 32'(n), 32'd32);

    // Reset arriving with a read request
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = AW'(0);
    rst        = 1'b1;
    cycle();
    check("rst_mid_rd_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_mid_rd_ready", 32'(bus.ready_o), 32'd0);
    bus.req_i = 1'b0;
    rst       = 1'b0;
    wait_ready(n);
    check("clr_len_rd_rst", 32'(n), 32'd32);

`ifdef RAM_PARITY_EN
    // Parity injection and clean read
    do_write(7, 8'h5A, 1'b1);
    do_read(7);
    do_read(0);
    cycle();
    check("perr_idle", 32'(bus.perr_o), 32'd0);
`endif

    // Random write/read traffic against the model
    for (int i = 0; i < 20; i++) begin
      int a;
      a = int'($urandom_range(DEPTH - 1, 0));
      if ($urandom_range(1, 0) == 1) do_write(a, DW'($urandom_range(255, 0)), 1'b0);
      else do_read(a);
    end
    repeat (3) cycle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
